// File: rtl/capture_pkg.sv
// capture_pkg: state encoding, default widths and the segment-period helper
// shared by the capture sequencer and its segment timer.
package capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_GO = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam int SAMPLES_W_DEF  = 20;
  localparam int SEGMENTS_W_DEF = 16;
  localparam int PERIOD_W       = 32;

  // A segment period must leave at least one idle cycle after the last write.
  function automatic logic [PERIOD_W-1:0] eff_period(input logic [PERIOD_W-1:0] cycles,
                                                     input logic [PERIOD_W-1:0] samples);
    return (cycles <= samples) ? samples + PERIOD_W'(1) : cycles;
  endfunction

endpackage

// File: rtl/segment_timer.sv
// segment_timer: one-shot period down-counter that requests the start of the
// next segment. Only present when SEGMENT_CYCLE_TRIGGER_EN is defined.
`ifdef SEGMENT_CYCLE_TRIGGER_EN
module segment_timer
  import capture_pkg::*;
(
  input  logic                adc_clk,
  input  logic                reset,
  input  logic                clear_i,
  input  logic                load_i,
  input  logic [PERIOD_W-1:0] period_i,
  output logic                fire_o
);

  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                run_q, run_d;

  // Reload on every segment start, count down once, stop at zero.
  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (clear_i) begin
      cnt_d = '0;
      run_d = 1'b0;
    end else if (load_i) begin
      cnt_d = period_i - PERIOD_W'(1);
      run_d = 1'b1;
    end else if (run_q) begin
      if (cnt_q == '0) run_d = 1'b0;
      else             cnt_d = cnt_q - PERIOD_W'(1);
    end
  end

  // Counter state registers.
  always_ff @(posedge adc_clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  // Fires in the cycle before the next segment's first write.
  assign fire_o = run_q && (cnt_q == '0);

endmodule
`endif

// File: rtl/capture_sequencer.sv
// capture_sequencer: turns trigger-unit go pulses into per-segment FIFO write
// bursts, counts samples/segments, flags missed triggers and signals done.
// Optional feature macro: SEGMENT_CYCLE_TRIGGER_EN (later segments started by
// a fixed-period timer instead of go pulses).
module capture_sequencer
  import capture_pkg::*;
#(
  parameter int SAMPLES_W  = SAMPLES_W_DEF,
  parameter int SEGMENTS_W = SEGMENTS_W_DEF
) (
  input  logic                  adc_clk,
  input  logic                  reset,
  input  logic                  arm_i,
  input  logic                  capture_active_i,
  input  logic                  capture_go_i,
  input  logic [SAMPLES_W-1:0]  num_samples_i,
  input  logic [SEGMENTS_W-1:0] num_segments_i,
  input  logic [PERIOD_W-1:0]   segment_cycles_i,
  output logic                  fifo_wr_en_o,
  output logic                  segment_start_o,
  output logic                  capture_done_o,
  output logic [SEGMENTS_W-1:0] segment_count_o,
  output logic                  missed_go_o,
  output logic [1:0]            state_o
);

  state_e                state_q, state_d;
  logic [SAMPLES_W-1:0]  sample_cnt_q, sample_cnt_d;
  logic [SAMPLES_W-1:0]  eff_samples_q, eff_samples_d;
  logic [SEGMENTS_W-1:0] eff_segments_q, eff_segments_d;
  logic [SEGMENTS_W-1:0] seg_cnt_q, seg_cnt_d;
  logic                  wr_en_q, wr_en_d;
  logic                  start_q, start_d;
  logic                  done_q, done_d;
  logic                  missed_q, missed_d;

  logic [SAMPLES_W-1:0]  eff_samples_in;
  logic [SEGMENTS_W-1:0] eff_segments_in;
  logic [SEGMENTS_W-1:0] seg_cnt_inc;
  logic                  go_accept;
  logic                  go_is_miss;

  // A zero count means "one".
  assign eff_samples_in  = (num_samples_i == '0) ? SAMPLES_W'(1) : num_samples_i;
  assign eff_segments_in = (num_segments_i == '0) ? SEGMENTS_W'(1) : num_segments_i;
  assign seg_cnt_inc     = seg_cnt_q + SEGMENTS_W'(1);

`ifdef SEGMENT_CYCLE_TRIGGER_EN
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                timer_fire;

  segment_timer u_segment_timer (
    .adc_clk  (adc_clk),
    .reset    (reset),
    .clear_i  (state_q == ST_IDLE),
    .load_i   (start_d),
    .period_i (period_q),
    .fire_o   (timer_fire)
  );

  // Only the first segment waits for a go pulse; later go pulses are ignored.
  assign go_accept  = (seg_cnt_q == '0) ? (capture_go_i && capture_active_i) : timer_fire;
  assign go_is_miss = capture_go_i && (seg_cnt_q == '0);

  // Segment period is latched together with the rest of the configuration.
  always_comb begin
    period_d = period_q;
    if (state_q == ST_IDLE && arm_i)
      period_d = eff_period(segment_cycles_i, PERIOD_W'(eff_samples_in));
  end

  // Period register.
  always_ff @(posedge adc_clk or posedge reset) begin
    if (reset) period_q <= '0;
    else       period_q <= period_d;
  end
`else
  logic unused_segment_cycles;
  assign unused_segment_cycles = ^segment_cycles_i;

  assign go_accept  = capture_go_i && capture_active_i;
  assign go_is_miss = capture_go_i;
`endif

  // Next-state and registered-output logic; abort (arm low) has priority.
  always_comb begin
    state_d        = state_q;
    sample_cnt_d   = sample_cnt_q;
    eff_samples_d  = eff_samples_q;
    eff_segments_d = eff_segments_q;
    seg_cnt_d      = seg_cnt_q;
    missed_d       = missed_q;
    wr_en_d        = 1'b0;
    start_d        = 1'b0;
    done_d         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arm_i) begin
          state_d        = ST_WAIT_GO;
          seg_cnt_d      = '0;
          missed_d       = 1'b0;
          eff_samples_d  = eff_samples_in;
          eff_segments_d = eff_segments_in;
        end
      end
      ST_WAIT_GO: begin
        if (!arm_i) begin
          state_d = ST_IDLE;
        end else if (go_accept) begin
          state_d      = ST_CAPTURE;
          sample_cnt_d = '0;
          wr_en_d      = 1'b1;
          start_d      = 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (go_is_miss) missed_d = 1'b1;
        if (!arm_i) begin
          state_d = ST_IDLE;
        end else if (sample_cnt_q == eff_samples_q - SAMPLES_W'(1)) begin
          seg_cnt_d = seg_cnt_inc;
          if (seg_cnt_inc == eff_segments_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_WAIT_GO;
          end
        end else begin
          sample_cnt_d = sample_cnt_q + SAMPLES_W'(1);
          wr_en_d      = 1'b1;
        end
      end
      ST_DONE: begin
        if (!arm_i) state_d = ST_IDLE;
        else        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state, counters and outputs.
  always_ff @(posedge adc_clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      sample_cnt_q   <= '0;
      eff_samples_q  <= '0;
      eff_segments_q <= '0;
      seg_cnt_q      <= '0;
      wr_en_q        <= 1'b0;
      start_q        <= 1'b0;
      done_q         <= 1'b0;
      missed_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      sample_cnt_q   <= sample_cnt_d;
      eff_samples_q  <= eff_samples_d;
      eff_segments_q <= eff_segments_d;
      seg_cnt_q      <= seg_cnt_d;
      wr_en_q        <= wr_en_d;
      start_q        <= start_d;
      done_q         <= done_d;
      missed_q       <= missed_d;
    end
  end

  assign fifo_wr_en_o    = wr_en_q;
  assign segment_start_o = start_q;
  assign capture_done_o  = done_q;
  assign segment_count_o = seg_cnt_q;
  assign missed_go_o     = missed_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// tb_capture_sequencer: table-driven and randomized checks of the capture
// sequencer against an event-level model of segment bursts.
module tb_capture_sequencer;

  localparam int SW   = 20;
  localparam int GW   = 16;
  localparam int LMAX = 96;
`ifdef SEGMENT_CYCLE_TRIGGER_EN
  localparam bit TIMED = 1'b1;
`else
  localparam bit TIMED = 1'b0;
`endif

  logic          adc_clk = 1'b0;
  logic          reset;
  logic          arm_i;
  logic          capture_active_i;
  logic          capture_go_i;
  logic [SW-1:0] num_samples_i;
  logic [GW-1:0] num_segments_i;
  logic [31:0]   segment_cycles_i;
  logic          fifo_wr_en_o;
  logic          segment_start_o;
  logic          capture_done_o;
  logic [GW-1:0] segment_count_o;
  logic          missed_go_o;
  logic [1:0]    state_o;

  capture_sequencer #(.SAMPLES_W(SW), .SEGMENTS_W(GW)) dut (
    .adc_clk          (adc_clk),
    .reset            (reset),
    .arm_i            (arm_i),
    .capture_active_i (capture_active_i),
    .capture_go_i     (capture_go_i),
    .num_samples_i    (num_samples_i),
    .num_segments_i   (num_segments_i),
    .segment_cycles_i (segment_cycles_i),
    .fifo_wr_en_o     (fifo_wr_en_o),
    .segment_start_o  (segment_start_o),
    .capture_done_o   (capture_done_o),
    .segment_count_o  (segment_count_o),
    .missed_go_o      (missed_go_o),
    .state_o          (state_o)
  );

  always #5 adc_clk = ~adc_clk;

  int total = 0;
  int bad   = 0;

  // Current scenario: arm high in cycles [sc_arm_on, sc_arm_off).
  int sc_samples, sc_segments, sc_cycles, sc_arm_on, sc_arm_off, sc_len;
  bit sc_scramble;
  bit sc_go[LMAX];
  bit sc_act[LMAX];

  // Expected per-cycle outputs.
  bit ex_wr[LMAX], ex_start[LMAX], ex_done[LMAX], ex_missed[LMAX];
  int ex_seg[LMAX], ex_state[LMAX];

  typedef struct {
    int samples, segments, cycles, drop;
    int g0, g1, g2;
    int exp_writes, exp_segs, exp_missed, exp_done;
  } vec_t;

  vec_t tbl[$];

  // Model: place each segment's write burst, then derive counts, done, misses.
  task automatic build_model();
    int effs, effg, per, ready, count, last_s, s, m, e;
    bit found;
    effs = (sc_samples == 0) ? 1 : sc_samples;
    effg = (sc_segments == 0) ? 1 : sc_segments;
    per  = (sc_cycles <= effs) ? effs + 1 : sc_cycles;
    for (int c = 0; c < LMAX; c++) begin
      ex_wr[c] = 0; ex_start[c] = 0; ex_done[c] = 0; ex_missed[c] = 0; ex_seg[c] = 0;
      ex_state[c] = (c >= sc_arm_on + 1 && c <= sc_arm_off) ? 1 : 0;
    end
    ready = sc_arm_on + 1; count = 0; last_s = 0; s = 0;
    while (1'b1) begin
      found = 0;
      if (TIMED && count > 0) begin
        s = last_s + per;
        found = (s - 1 < sc_arm_off);
      end else begin
        for (int g = ready; g < sc_len; g++)
          if (!found && sc_go[g] && sc_act[g] && g < sc_arm_off) begin
            found = 1; s = g + 1;
          end
      end
      if (!found || s >= sc_len) break;
      m = s + effs - 1;
      e = (m < sc_arm_off) ? m : sc_arm_off;
      ex_start[s] = 1;
      for (int c = s; c <= e && c < sc_len; c++) begin
        ex_wr[c] = 1; ex_state[c] = 2;
      end
      for (int g = s; g <= e && g < sc_len; g++)
        if (sc_go[g] && (!TIMED || count == 0))
          for (int c = g + 1; c < sc_len; c++) ex_missed[c] = 1;
      if (m >= sc_arm_off) break;
      count++;
      for (int c = m + 1; c < sc_len; c++) ex_seg[c] = count;
      ready = m + 1; last_s = s;
      if (count == effg) begin
        for (int c = m + 1; c <= sc_arm_off && c < sc_len; c++) begin
          ex_done[c] = 1; ex_state[c] = 3;
        end
        break;
      end
    end
  endtask

  task automatic run_scenario(input string name, output int writes, output int seg_last,
                              output int miss_last, output int done_first);
    build_model();
    reset = 1'b1; arm_i = 1'b0; capture_go_i = 1'b0; capture_active_i = 1'b0;
    num_samples_i    = SW'(sc_samples);
    num_segments_i   = GW'(sc_segments);
    segment_cycles_i = 32'(sc_cycles);
    @(posedge adc_clk);
    @(negedge adc_clk);
    reset = 1'b0;
    writes = 0; done_first = -1;
    for (int c = 0; c < sc_len; c++) begin
      @(posedge adc_clk);
      #1;
      arm_i            = (c >= sc_arm_on && c < sc_arm_off);
      capture_go_i     = sc_go[c];
      capture_active_i = sc_act[c];
      if (sc_scramble && c > sc_arm_on) begin
        num_samples_i    = SW'($urandom_range(9, 0));
        num_segments_i   = GW'($urandom_range(5, 0));
        segment_cycles_i = 32'($urandom_range(12, 0));
      end
      total++;
      if (state_o !== 2'(ex_state[c]) || fifo_wr_en_o !== ex_wr[c] ||
          segment_start_o !== ex_start[c] || capture_done_o !== ex_done[c] ||
          missed_go_o !== ex_missed[c] || segment_count_o !== GW'(ex_seg[c])) begin
        bad++;
        $display("FAIL %s cycle %0d: got st=%0d wr=%0b start=%0b done=%0b miss=%0b seg=%0d, want st=%0d wr=%0b start=%0b done=%0b miss=%0b seg=%0d",
                 name, c, state_o, fifo_wr_en_o, segment_start_o, capture_done_o, missed_go_o,
                 segment_count_o, ex_state[c], ex_wr[c], ex_start[c], ex_done[c], ex_missed[c], ex_seg[c]);
      end
      if (fifo_wr_en_o === 1'b1) writes++;
      if (capture_done_o === 1'b1 && done_first < 0) done_first = c;
    end
    seg_last  = int'(segment_count_o);
    miss_last = int'(missed_go_o);
    arm_i = 1'b0; capture_go_i = 1'b0;
    $display("scenario %s: samples=%0d segments=%0d writes=%0d segs=%0d missed=%0d done_at=%0d",
             name, sc_samples, sc_segments, writes, seg_last, miss_last, done_first);
  endtask

  task automatic check_int(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  initial begin
    int w, sg, ms, df;
    vec_t v;

    // Reset state.
    reset = 1'b1; arm_i = 1'b0; capture_go_i = 1'b0; capture_active_i = 1'b0;
    num_samples_i = '0; num_segments_i = '0; segment_cycles_i = '0;
    #1;
    check_int("reset_outputs",
              int'({state_o, fifo_wr_en_o, segment_start_o, capture_done_o, missed_go_o, segment_count_o}), 0);

    // {samples, segments, seg_cycles, arm_drop, go0, go1, go2, writes, segs, missed, done_first}
`ifdef SEGMENT_CYCLE_TRIGGER_EN
    tbl.push_back('{4, 3, 10, 50, 10, -1, -1, 12, 3, 0, 35});
    tbl.push_back('{4, 3,  2, 50, 10, -1, -1, 12, 3, 0, 25});
    tbl.push_back('{4, 3, 10, 50, 10, 22, -1, 12, 3, 0, 35});
    tbl.push_back('{4, 2, 10, 50, 10, 12, -1,  8, 2, 1, 25});
`else
    tbl.push_back('{8, 1, 0, 40, 10, -1, -1,  8, 1, 0, 19});
    tbl.push_back('{4, 3, 0, 50, 10, 20, 30, 12, 3, 0, 35});
    tbl.push_back('{8, 1, 0, 40, 10, 14, -1,  8, 1, 1, 19});
    tbl.push_back('{0, 0, 0, 30, 10, -1, -1,  1, 1, 0, 12});
    tbl.push_back('{8, 1, 0, 13, 10, -1, -1,  3, 0, 0, -1});
    tbl.push_back('{4, 3, 0, 40, 10, 14, 15,  8, 2, 1, -1});
    tbl.push_back('{4, 3, 0, 20, 10, 25, -1,  4, 1, 0, -1});
    tbl.push_back('{2, 1, 0, 30,  0,  5, -1,  2, 1, 0,  8});
    tbl.push_back('{2, 1, 0, 30,  5, 10, -1,  2, 1, 0,  8});
    tbl.push_back('{4, 2, 0, 14, 10, -1, -1,  4, 0, 0, -1});
`endif

    foreach (tbl[i]) begin
      v = tbl[i];
      sc_samples = v.samples; sc_segments = v.segments; sc_cycles = v.cycles;
      sc_arm_on = 0; sc_arm_off = v.drop; sc_len = 64; sc_scramble = 0;
      for (int c = 0; c < LMAX; c++) begin sc_go[c] = 0; sc_act[c] = 1; end
      if (v.g0 >= 0) sc_go[v.g0] = 1;
      if (v.g1 >= 0) sc_go[v.g1] = 1;
      if (v.g2 >= 0) sc_go[v.g2] = 1;
      run_scenario($sformatf("vec%0d", i), w, sg, ms, df);
      check_int($sformatf("vec%0d_writes", i), w, v.exp_writes);
      check_int($sformatf("vec%0d_segs", i), sg, v.exp_segs);
      check_int($sformatf("vec%0d_missed", i), ms, v.exp_missed);
      check_int($sformatf("vec%0d_done_at", i), df, v.exp_done);
    end

    // Randomized scenarios, with configuration inputs changing after arming.
    for (int r = 0; r < 40; r++) begin
      sc_samples  = int'($urandom_range(6, 0));
      sc_segments = int'($urandom_range(4, 0));
      sc_cycles   = int'($urandom_range(12, 0));
      sc_arm_on   = int'($urandom_range(3, 0));
      sc_arm_off  = int'($urandom_range(LMAX + 20, 10));
      sc_len      = LMAX;
      sc_scramble = 1;
      for (int c = 0; c < LMAX; c++) begin
        sc_go[c]  = ($urandom_range(5, 0) == 0);
        sc_act[c] = ($urandom_range(3, 0) != 0);
      end
      run_scenario($sformatf("rand%0d", r), w, sg, ms, df);
    end

    // Asynchronous reset in the middle of a segment clears outputs at once.
    reset = 1'b1; arm_i = 1'b0; capture_go_i = 1'b0; capture_active_i = 1'b1;
    num_samples_i = SW'(8); num_segments_i = GW'(1); segment_cycles_i = 32'd0;
    @(posedge adc_clk);
    @(negedge adc_clk);
    reset = 1'b0;
    @(posedge adc_clk); #1; arm_i = 1'b1;
    @(posedge adc_clk); #1; capture_go_i = 1'b1;
    @(posedge adc_clk); #1; capture_go_i = 1'b0;
    check_int("async_pre_wr_state", int'({state_o, fifo_wr_en_o}), 5);
    #2 reset = 1'b1;
    #1;
    check_int("async_reset_outputs",
              int'({state_o, fifo_wr_en_o, segment_start_o, capture_done_o, missed_go_o, segment_count_o}), 0);
    @(negedge adc_clk); reset = 1'b0;
    @(posedge adc_clk); #1;
    check_int("async_rearm_state", int'(state_o), 1);
    arm_i = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
